// File: rtl/spu_sm_norm.sv
// Softmax normalizer: buffers a vector of exp values, divides 2^23 by their sum,
// then streams each element scaled by the reciprocal as an 8-bit probability.
module spu_sm_norm #(
  parameter int MAX_LEN = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [6:0]  vec_len,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        busy,
  output logic [15:0] sum_q
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [6:0] LEN_MAX = 7'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, ACC, RECI, NORM} state_t;

  state_t      state_q, state_d;
  logic [6:0]  len_q, len_d;
  logic [6:0]  idx_q, idx_d;
  logic [6:0]  rd_ptr_q, rd_ptr_d;
  logic [15:0] rem_q, rem_d;
  logic [23:0] quo_q, quo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] sum_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_last_q, out_last_d;
  logic        wr_en;
  logic [16:0] trial;
  logic [31:0] prod;
  logic [16:0] scaled;
  logic [7:0]  mem_q;
  logic [7:0]  buffer [MAX_LEN];

  // mem_q always mirrors buffer[rd_ptr_q], so the next element is ready to load
  assign prod   = {24'd0, mem_q} * {8'd0, quo_q} + 32'h0000_4000;
  assign scaled = 17'(prod >> 15);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    rd_ptr_d    = rd_ptr_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    wr_en       = 1'b0;
    trial       = {rem_q, (cnt_q == 5'd0)};
    case (state_q)
      IDLE: begin
        if (start) begin
          if (vec_len == 7'd0)        len_d = 7'd1;
          else if (vec_len > LEN_MAX) len_d = LEN_MAX;
          else                        len_d = vec_len;
          idx_d    = '0;
          rd_ptr_d = '0;
          sum_d    = '0;
          state_d  = ACC;
        end
      end
      ACC: begin
        if (in_valid) begin
          wr_en = 1'b1;
          sum_d = sum_q + {8'd0, in_data};
          idx_d = idx_q + 7'd1;
          if (idx_q == len_q - 7'd1) begin
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = '0;
            state_d = (sum_d == 16'd0) ? NORM : RECI;
          end
        end
      end
      RECI: begin
        // dividend is 2^23: its only set bit enters on the first step
        if (trial >= {1'b0, sum_q}) begin
          rem_d = 16'(trial - {1'b0, sum_q});
          quo_d = {quo_q[22:0], 1'b1};
        end else begin
          rem_d = trial[15:0];
          quo_d = {quo_q[22:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd23) state_d = NORM;
      end
      NORM: begin
        if (!out_valid_q || out_ready) begin
          if (rd_ptr_q < len_q) begin
            out_valid_d = 1'b1;
            out_data_d  = (|scaled[16:8]) ? 8'd255 : scaled[7:0];
            out_last_d  = (rd_ptr_q == len_q - 7'd1);
            rd_ptr_d    = rd_ptr_q + 7'd1;
          end else begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end
        end
        if (out_valid_q && out_ready && out_last_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      rd_ptr_q    <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      rd_ptr_q    <= rd_ptr_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) buffer[idx_q[AW-1:0]] <= in_data;
    mem_q <= buffer[rd_ptr_d[AW-1:0]];
  end

  assign in_ready  = (state_q == ACC);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_spu_sm_norm.sv
// Bench for spu_sm_norm: directed vector table, randomized vectors against an
// arithmetic softmax model, and a mid-vector reset sequence.
module tb_spu_sm_norm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  vec_len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;
  logic [15:0] sum_q;

  spu_sm_norm #(.MAX_LEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .sum_q(sum_q)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] vdata [64];
  int         exp_out [64];
  int         exp_sum;

  typedef struct {
    int len; int n;
    int d0; int d1; int d2; int d3; int dfill;
    int esum;
    int e0; int e1; int e2; int e3; int efill;
    int rdy;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: R = floor(2^23/sum), p = min(255, round(d*R / 2^15))
  task automatic build_expected(input int n);
    longint s, r, p;
    s = 0;
    for (int i = 0; i < n; i++) s += vdata[i];
    exp_sum = int'(s);
    r = (s == 0) ? 0 : (64'd1 << 23) / s;
    for (int i = 0; i < n; i++) begin
      p = (longint'(vdata[i]) * r + 16384) >> 15;
      exp_out[i] = (p > 255) ? 255 : int'(p);
    end
  endtask

  // Caller is at a negedge; start is raised immediately.
  task automatic run_vec(input int len_in, input int n, input int rdy_pct, input int vld_pct);
    int sent, got, last_acc, first_ov, first_ot, last_ot;
    logic stalled, pl;
    logic [7:0] pd;
    start = 1'b1;
    vec_len = 7'(len_in);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("sum_cleared", int'(sum_q), 0);
    sent = 0; got = 0; stalled = 1'b0; pd = '0; pl = 1'b0;
    last_acc = -1; first_ov = -1; first_ot = -1; last_ot = -1;
    for (int t = 0; t < 3000 && got < n; t++) begin
      if (stalled) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'(out_data), int'(pd));
        chk("hold_last", int'(out_last), int'(pl));
      end
      if (out_valid && first_ov < 0) first_ov = cyc;
      out_ready = ($urandom_range(99) < rdy_pct);
      if (out_valid && out_ready) begin
        chk("out_data", int'(out_data), exp_out[got]);
        chk("out_last", int'(out_last), (got == n - 1) ? 1 : 0);
        if (got == 0) first_ot = cyc;
        last_ot = cyc;
        got++;
      end
      stalled = out_valid && !out_ready;
      pd = out_data;
      pl = out_last;
      if (sent < n) begin
        in_valid = ($urandom_range(99) < vld_pct);
        in_data  = vdata[sent];
        if (in_valid && in_ready) begin
          sent++;
          last_acc = cyc;
        end
      end else begin
        in_valid = ($urandom_range(3) == 0);
        in_data  = 8'($urandom);
      end
      start   = busy && ($urandom_range(15) == 0);
      vec_len = 7'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    in_valid = 1'b0;
    chk("all_outputs", got, n);
    if (exp_sum != 0 && first_ov >= 0)
      chk("latency_le_27", (first_ov - last_acc - 1 <= 27) ? 1 : 0, 1);
    if (rdy_pct == 100 && got == n)
      chk("one_per_cycle", last_ot - first_ot, n - 1);
    @(negedge clk);
    chk("valid_low_after_last", int'(out_valid), 0);
    chk("idle_after_last", int'(busy), 0);
    chk("sum_held", int'(sum_q), exp_sum);
    $display("vector len_in=%0d n=%0d sum=%0d outputs=%0d", len_in, n, exp_sum, got);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_sum", int'(sum_q), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, len_in;
    tbl[0] = '{4,  4,  64, 64, 64, 64, 64,   256,   64, 64, 64, 64, 64,  100};
    tbl[1] = '{3,  3,  255, 0, 0, 0, 0,      255,   255, 0, 0, 0, 0,     100};
    tbl[2] = '{3,  3,  100, 100, 55, 0, 0,   255,   100, 100, 55, 0, 0,  100};
    tbl[3] = '{5,  5,  0, 0, 0, 0, 0,        0,     0, 0, 0, 0, 0,       100};
    tbl[4] = '{64, 64, 255, 255, 255, 255, 255, 16320, 4, 4, 4, 4, 4,   50};
    tbl[5] = '{1,  1,  200, 0, 0, 0, 0,      200,   255, 0, 0, 0, 0,     100};
    tbl[6] = '{0,  1,  10, 0, 0, 0, 0,       10,    255, 0, 0, 0, 0,     70};
    tbl[7] = '{100, 64, 255, 255, 255, 255, 255, 16320, 4, 4, 4, 4, 4,  100};

    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      for (int j = 0; j < 64; j++) begin
        vdata[j]   = 8'((j == 0) ? tbl[i].d0 : (j == 1) ? tbl[i].d1 :
                        (j == 2) ? tbl[i].d2 : (j == 3) ? tbl[i].d3 : tbl[i].dfill);
        exp_out[j] = (j == 0) ? tbl[i].e0 : (j == 1) ? tbl[i].e1 :
                     (j == 2) ? tbl[i].e2 : (j == 3) ? tbl[i].e3 : tbl[i].efill;
      end
      exp_sum = tbl[i].esum;
      run_vec(tbl[i].len, tbl[i].n, tbl[i].rdy, 100);
    end

    for (int r = 0; r < 16; r++) begin
      len_in = $urandom_range(100);
      n = (len_in == 0) ? 1 : (len_in > 64) ? 64 : len_in;
      for (int j = 0; j < 64; j++)
        vdata[j] = (r % 5 == 4) ? 8'd0 : 8'($urandom_range((r % 2 == 0) ? 255 : 15));
      build_expected(n);
      run_vec(len_in, n, (r % 3 == 0) ? 100 : 60, 75);
    end

    // Reset while the divider is running
    start = 1'b1;
    vec_len = 7'd4;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'd10;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("in_reci_busy", int'(busy), 1);
    chk("in_reci_no_ready", int'(in_ready), 0);
    chk("in_reci_no_valid", int'(out_valid), 0);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    vdata[0] = 8'd128;
    vdata[1] = 8'd128;
    build_expected(2);
    chk("model_128", exp_out[0], 128);
    run_vec(2, 2, 100, 100);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
